// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_pkg : shared constants, channel-select width helper, state   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clk_div_pkg;

  localparam int c_def_div = 64;
  localparam int c_div_w   = 27;

  // Snapshot of one channel's state at the default counter width.
  typedef struct packed {
    logic [c_div_w-1:0] cnt;
    logic [c_div_w-1:0] div_act;
    logic [c_div_w-1:0] div_shd;
    logic               pend;
    logic               run;
  } chan_state_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_chan : one divider channel with shadowed divisor             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clk_div_chan import clk_div_pkg::*; #(
  parameter int DIV_W   = c_div_w,
  parameter int DEF_DIV = c_def_div
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_ld_we,
  input  logic [DIV_W-1:0] i_ld_div,
  output logic             o_pending,
  output logic             o_clk_out,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] c_one = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_def = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_shd;
  logic             r_pend;
  logic             r_run;
  logic             r_clk_out;
  logic             r_tick;

  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_cnt_inc;
  logic             w_wrap;

  // Divisor in force once the current boundary has been taken.
  assign w_div_nxt = r_pend ? r_div_shd : r_div_act;
  assign w_cnt_inc = r_cnt + c_one;
  assign w_wrap    = (r_cnt == (r_div_act - c_one));

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div_act <= c_def;
      r_div_shd <= c_def;
      r_pend    <= 1'b0;
      r_run     <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      if (!i_en || !r_run) begin
        r_cnt     <= '0;
        r_div_act <= w_div_nxt;
        r_pend    <= 1'b0;
        if (i_en && (w_div_nxt != '0)) begin
          r_run     <= 1'b1;
          r_tick    <= 1'b1;
          r_clk_out <= (w_div_nxt > c_one);
        end else begin
          r_run     <= 1'b0;
        end
      end else if (i_sync || w_wrap) begin
        r_cnt     <= '0;
        r_div_act <= w_div_nxt;
        r_pend    <= 1'b0;
        if (w_div_nxt == '0) begin
          r_run     <= 1'b0;
        end else begin
          r_tick    <= 1'b1;
          r_clk_out <= (w_div_nxt > c_one);
        end
      end else begin
        r_cnt     <= w_cnt_inc;
        r_clk_out <= (w_cnt_inc < (r_div_act >> 1));
      end
      // Loads are only granted while nothing is pending, so this never
      // collides with a shadow being applied on the same edge.
      if (i_ld_we) begin
        r_div_shd <= i_ld_div;
        r_pend    <= 1'b1;
      end
    end
  end

  assign o_pending = r_pend;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_prog : NCH-channel programmable clock/tick divider           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clk_div_prog import clk_div_pkg::*; #(
  parameter  int NCH     = 4,
  parameter  int DIV_W   = c_div_w,
  parameter  int DEF_DIV = c_def_div,
  localparam int CH_W    = ch_width(NCH)
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             ld_valid,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [DIV_W-1:0] ld_div,
  output logic             ld_ready,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] w_ld_we;
  logic           w_ld_fire;

  // Out-of-range channels always accept so the load completes harmlessly.
  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (ld_ch == CH_W'(i)) ld_ready = ~pending[i];
    end
  end

  assign w_ld_fire = ld_valid & ld_ready;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      assign w_ld_we[g] = w_ld_fire && (ld_ch == CH_W'(g));

      clk_div_chan #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clki      (clki),
        .rst_n     (rst_n),
        .i_en      (en[g]),
        .i_sync    (sync),
        .i_ld_we   (w_ld_we[g]),
        .i_ld_div  (ld_div),
        .o_pending (pending[g]),
        .o_clk_out (clk_out[g]),
        .o_tick    (tick[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_div_prog : directed self-checking bench for clk_div_prog      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clk_div_prog;

  localparam int NCH   = 5;
  localparam int DIV_W = 27;

  logic             clki = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             ld_valid;
  logic [2:0]       ld_ch;
  logic [DIV_W-1:0] ld_div;
  logic             ld_ready;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int n_chk  = 0;
  int n_pass = 0;
  int n_hi, n_tk, n_both, n_t0, n_t1, acc;
  logic [4:0] v_clk, v_tk;

  clk_div_prog #(
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_DIV (64)
  ) dut (
    .clki     (clki),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .ld_valid (ld_valid),
    .ld_ch    (ld_ch),
    .ld_div   (ld_div),
    .ld_ready (ld_ready),
    .pending  (pending),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tk();
    @(posedge clki);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0;
    ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
    #23;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    tk();

    // Channel 0 alone at the reset divisor of 64.
    en = 5'b00001;
    tk();
    chk("start_tick", tick, 5'b00001);
    chk("start_clk", clk_out, 5'b00001);
    n_hi = 1; n_tk = 1; acc = 0;
    for (int i = 1; i < 64; i++) begin
      tk();
      n_hi += clk_out[0]; n_tk += tick[0];
      acc |= int'({clk_out[4:1], tick[4:1]});
    end
    chk("div64_high_cycles", n_hi, 32);
    chk("div64_ticks", n_tk, 1);
    chk("idle_chans_quiet", acc, 0);
    tk();
    chk("div64_second_tick", tick[0], 1);

    // Channel 1: load 5 mid-period, then hold a second load while pending.
    en = 5'b00011;
    tk();
    chk("ch1_start_tick", tick[1], 1);
    for (int i = 0; i < 10; i++) tk();
    ld_valid = 1'b1; ld_ch = 3'd1; ld_div = 27'd5;
    #1;
    chk("ch1_ready_before", ld_ready, 1);
    tk();
    ld_div = 27'd9;
    #1;
    chk("ch1_pending_set", pending[1], 1);
    chk("ch1_ready_blocked", ld_ready, 0);
    n_hi = 0; n_tk = 0;
    for (int i = 12; i < 64; i++) begin
      tk();
      n_hi += pending[1]; n_tk += tick[1];
    end
    chk("ch1_pending_held", n_hi, 52);
    chk("ch1_no_early_tick", n_tk, 0);
    tk();
    chk("ch1_wrap_tick", tick[1], 1);
    chk("ch1_wrap_pend_clr", pending[1], 0);
    chk("ch1_ready_after", ld_ready, 1);
    v_clk[0] = clk_out[1]; v_tk[0] = tick[1];
    tk();
    chk("ch1_second_load", pending[1], 1);
    ld_valid = 1'b0;
    v_clk[1] = clk_out[1]; v_tk[1] = tick[1];
    for (int i = 2; i < 5; i++) begin
      tk();
      v_clk[i] = clk_out[1]; v_tk[i] = tick[1];
    end
    chk("div5_clk_pattern", v_clk, 5'b00011);
    chk("div5_tick_pattern", v_tk, 5'b00001);
    tk();
    chk("div9_tick", tick[1], 1);
    chk("div9_pend_clr", pending[1], 0);
    n_hi = 1; n_tk = 0;
    for (int i = 0; i < 8; i++) begin
      tk();
      n_hi += clk_out[1]; n_tk += tick[1];
    end
    chk("div9_high_cycles", n_hi, 4);
    chk("div9_ticks", n_tk, 0);
    tk();
    chk("div9_next_tick", tick[1], 1);

    // Channel 2: divisor 1, then divisor 0 stops it.
    ld_valid = 1'b1; ld_ch = 3'd2; ld_div = 27'd1;
    tk();
    ld_valid = 1'b0;
    chk("ch2_pend_set", pending[2], 1);
    tk();
    chk("ch2_idle_apply", pending[2], 0);
    en = 5'b00111;
    n_tk = 0; n_hi = 0;
    for (int i = 0; i < 6; i++) begin
      tk();
      n_tk += tick[2]; n_hi += clk_out[2];
    end
    chk("div1_ticks", n_tk, 6);
    chk("div1_clk_low", n_hi, 0);
    ld_valid = 1'b1; ld_ch = 3'd2; ld_div = 27'd0;
    tk();
    ld_valid = 1'b0;
    chk("div0_load_on_wrap_pend", pending[2], 1);
    chk("div0_load_on_wrap_tick", tick[2], 1);
    tk();
    chk("div0_stopped", {pending[2], clk_out[2], tick[2]}, 0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tk();
      acc |= int'({clk_out[2], tick[2]});
    end
    chk("div0_stays_off", acc, 0);

    // Channels 0/1 at 4 and 6, started out of phase, then synced.
    en = '0; ld_valid = 1'b1; ld_ch = 3'd0; ld_div = 27'd4;
    tk();
    ld_ch = 3'd1; ld_div = 27'd6;
    tk();
    ld_valid = 1'b0;
    tk();
    chk("idle_loads_applied", pending, 0);
    en = 5'b00001;
    tk(); tk(); tk();
    en = 5'b00011;
    tk(); tk();
    chk("out_of_phase", tick[1:0], 2'b01);
    tk();
    sync = 1'b1;
    tk();
    sync = 1'b0;
    chk("sync_tick", tick[1:0], 2'b11);
    chk("sync_clk", clk_out[1:0], 2'b11);
    n_both = 0; n_t0 = 0; n_t1 = 0;
    for (int i = 0; i < 11; i++) begin
      tk();
      n_both += int'(tick[0] & tick[1]); n_t0 += tick[0]; n_t1 += tick[1];
    end
    chk("sync_no_common", n_both, 0);
    chk("sync_ch0_ticks", n_t0, 2);
    chk("sync_ch1_ticks", n_t1, 1);
    tk();
    chk("sync_common_12", tick[1:0], 2'b11);

    // Out-of-range channel select.
    ld_valid = 1'b1; ld_ch = 3'd7; ld_div = 27'd3;
    #1;
    chk("oob_ready", ld_ready, 1);
    tk();
    ld_valid = 1'b0;
    chk("oob_no_pending", pending, 0);
    tk(); tk(); tk();
    chk("oob_ch0_period", tick[1:0], 2'b01);
    chk("oob_clk", clk_out[1:0], 2'b01);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk", clk_out, 0);
    chk("async_rst_tick", tick, 0);
    en = 5'b00001;
    #3;
    rst_n = 1'b1;
    tk();
    chk("post_rst_start", tick, 5'b00001);
    n_hi = 1; n_tk = 0;
    for (int i = 1; i < 64; i++) begin
      tk();
      n_hi += clk_out[0]; n_tk += tick[0];
    end
    chk("post_rst_high", n_hi, 32);
    chk("post_rst_ticks", n_tk, 0);
    tk();
    chk("post_rst_div64", tick[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
